// File: rtl/mips_pkg.sv
// Shared MIPS front-end types, boot/exception vectors and the alignment helper.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_t;
  typedef logic [XLEN-1:0] addr_t;

  localparam addr_t       RESET_VEC_DEF = 32'hBFC0_0000;
  localparam addr_t       EXC_VEC_DEF   = 32'h8000_0180;
  localparam word_t       INST_NOP      = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEF   = 4;

  // True when a byte address is not on a word boundary.
  function automatic logic is_misaligned(input addr_t a);
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC generation: holds pc_q and selects exception, redirect, increment or hold.
// With FETCH_ALIGN_CHECK_EN undefined, redirect targets are forced to word alignment.
module fetch_pc_gen
  import mips_pkg::*;
#(
  parameter addr_t       RESET_VEC = RESET_VEC_DEF,
  parameter addr_t       EXC_VEC   = EXC_VEC_DEF,
  parameter int unsigned PC_STEP   = PC_STEP_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  exc_valid,
  input  logic  redirect_valid,
  input  addr_t redirect_pc,
  input  logic  advance,
  output addr_t pc_q
);

  addr_t target;

`ifdef FETCH_ALIGN_CHECK_EN
  // Keep the raw target so a misaligned fetch reaches decode and is flagged there.
  assign target = redirect_pc;
`else
  assign target = redirect_pc & ~addr_t'(3);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_VEC;
    end else if (exc_valid) begin
      pc_q <= EXC_VEC;
    end else if (redirect_valid) begin
      pc_q <= target;
    end else if (advance) begin
      pc_q <= pc_q + XLEN'(PC_STEP);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives im_addr, pairs im_data with its PC, presents to decode.
// Optional misaligned-PC flagging is enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_unit
  import mips_pkg::*;
#(
  parameter addr_t       RESET_VEC = RESET_VEC_DEF,
  parameter addr_t       EXC_VEC   = EXC_VEC_DEF,
  parameter int unsigned PC_STEP   = PC_STEP_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] im_addr,
  input  logic [31:0] im_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        exc_valid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        addr_err
);

  addr_t pc_q;
  addr_t fq_pc_q;
  logic  fq_v_q;
  logic  advance;
  logic  stall;

  assign advance = !out_valid || out_ready;
  assign stall   = !advance && !exc_valid && !redirect_valid;

  // Re-read the in-flight address while stalled so im_data keeps matching fq_pc_q.
  assign im_addr = stall ? fq_pc_q : pc_q;

  fetch_pc_gen #(
    .RESET_VEC (RESET_VEC),
    .EXC_VEC   (EXC_VEC),
    .PC_STEP   (PC_STEP)
  ) u_pc_gen (
    .clk            (clk),
    .rst            (rst),
    .exc_valid      (exc_valid),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .advance        (advance),
    .pc_q           (pc_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fq_pc_q   <= RESET_VEC;
      fq_v_q    <= 1'b0;
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_inst  <= '0;
    end else if (exc_valid || redirect_valid) begin
      fq_v_q    <= 1'b0;
      out_valid <= 1'b0;
    end else if (advance) begin
      out_valid <= fq_v_q;
      out_pc    <= fq_pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
      out_inst  <= is_misaligned(fq_pc_q) ? INST_NOP : im_data;
`else
      out_inst  <= im_data;
`endif
      fq_pc_q   <= pc_q;
      fq_v_q    <= 1'b1;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_err <= 1'b0;
    end else if (!exc_valid && !redirect_valid && advance) begin
      addr_err <= is_misaligned(fq_pc_q);
    end
  end
`else
  assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; instruction memory returns ~address one cycle after im_addr.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] im_addr;
  logic [31:0] im_data = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        exc_valid;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        addr_err;

  int total = 0;
  int bad   = 0;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .im_addr        (im_addr),
    .im_data        (im_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .exc_valid      (exc_valid),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .addr_err       (addr_err)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory image: word at address A reads as ~A.
  always @(posedge clk) im_data <= ~im_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_entry(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_pc"}, out_pc, pc);
    check({tag, "_inst"}, out_inst, ~pc);
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; exc_valid = 1'b0;
    #1;
    check("rst_im_addr", im_addr, 32'hBFC0_0000);
    repeat (3) step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_inst", out_inst, 32'h0);
    check("rst_err", 32'(addr_err), 32'd0);
    rst = 1'b0;

    // Boot: first entry on the second edge after release.
    step();
    check("boot_e1_valid", 32'(out_valid), 32'd0);
    step();
    expect_entry("boot0", 32'hBFC0_0000);
    step();
    expect_entry("boot1", 32'hBFC0_0004);
    step();
    expect_entry("boot2", 32'hBFC0_0008);

    // Redirect while presenting BFC00008; BFC0000C must never appear.
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    step();
    redirect_valid = 1'b0;
    check("redir_e1_valid", 32'(out_valid), 32'd0);
    step();
    check("redir_e2_valid", 32'(out_valid), 32'd0);
    step();
    expect_entry("redir0", 32'h8000_0200);
    step();
    expect_entry("redir1", 32'h8000_0204);

    // Back-pressure on 80000204.
    out_ready = 1'b0;
    #1;
    check("bp_im_addr0", im_addr, 32'h8000_0208);
    for (int i = 0; i < 4; i++) begin
      step();
      expect_entry("bp_hold", 32'h8000_0204);
      check("bp_im_addr", im_addr, 32'h8000_0208);
    end
    out_ready = 1'b1;
    step();
    expect_entry("bp_rel0", 32'h8000_0208);
    step();
    expect_entry("bp_rel1", 32'h8000_020C);

    // Exception wins over a simultaneous redirect.
    exc_valid = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h9FC0_0000;
    step();
    exc_valid = 1'b0; redirect_valid = 1'b0;
    check("exc_e1_valid", 32'(out_valid), 32'd0);
    step();
    step();
    expect_entry("exc0", 32'h8000_0180);
    step();
    expect_entry("exc1", 32'h8000_0184);

    // 32-bit PC wrap.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    expect_entry("wrap0", 32'hFFFF_FFF8);
    step();
    expect_entry("wrap1", 32'hFFFF_FFFC);
    step();
    expect_entry("wrap2", 32'h0000_0000);

    // Misaligned redirect target.
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0202;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    check("mis_valid", 32'(out_valid), 32'd1);
`ifdef FETCH_ALIGN_CHECK_EN
    check("mis_pc", out_pc, 32'h8000_0202);
    check("mis_inst", out_inst, 32'h0);
    check("mis_err", 32'(addr_err), 32'd1);
    step();
    check("mis_next_pc", out_pc, 32'h8000_0206);
    check("mis_next_err", 32'(addr_err), 32'd1);
`else
    check("mis_pc", out_pc, 32'h8000_0200);
    check("mis_inst", out_inst, ~32'h8000_0200);
    check("mis_err", 32'(addr_err), 32'd0);
    step();
    expect_entry("mis_next", 32'h8000_0204);
`endif

    // Asynchronous reset in the middle of a stall.
    out_ready = 1'b0;
    step();
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_im_addr", im_addr, 32'hBFC0_0000);
    check("mid_rst_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
    expect_entry("reboot0", 32'hBFC0_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
